clk_gate_ctrl: RTL and testbench
================================

# clk_gate_ctrl

Clock-gate enable controller sitting directly upstream of the `GATED_CLK_CELL` instance for one clock domain; it produces that cell's `EN` and `TE` inputs. It watches a domain activity flag. After a programmable number of consecutive idle cycles it runs a sleep request/acknowledge handshake with the domain, then drops the enable. On a wake request it restores the enable and reports clock-ready after a fixed settle delay.

## Interface
- `IDLE_CYCLES`, default 16: consecutive idle samples required before requesting sleep; legal range 1 .. 2^`CNT_W`-1.
- `WAKE_CYCLES`, default 2: settle cycles between enable re-assertion and `CLK_READY`; legal range 1 .. 2^`CNT_W`-1.
- `CNT_W`, default 8: width of the shared idle/wake counter.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `CLK_IN` in 1: free-running (ungated) clock.
- `RST` in 1: asynchronous, active-high reset.
- `BUSY` in 1: gated domain has work in flight.
- `WAKE_REQ` in 1: external request to run the domain clock.
- `FORCE_ON` in 1: software override that keeps the clock on.
- `SLEEP_ACK` in 1: domain has drained and accepts clock-off.
- `SCAN_EN` in 1: DFT scan enable.
- `GATE_EN` out 1: drives `EN` of the gate cell.
- `GATE_TE` out 1: drives `TE` of the gate cell.
- `SLEEP_REQ` out 1: asks the domain to drain.
- `CLK_READY` out 1: gated clock is running and settled.
- `GATED` out 1: status; the clock is currently off.

## Operation
- Reset values (asserted asynchronously): state RUN, `GATE_EN`=1, `CLK_READY`=1, `SLEEP_REQ`=0, `GATED`=0, counter=0. Reset always leaves the clock on.
- `GATE_TE` = `SCAN_EN`. This is the only combinational path. All other outputs are registered.
- Definition: `wake_cond` = `BUSY` | `WAKE_REQ` | `FORCE_ON`.
- **RUN**
  - Counter clears on `wake_cond` and increments otherwise.
  - When the counter equals `IDLE_CYCLES`-1 and `wake_cond`=0, go to DRAIN and set `SLEEP_REQ`=1.
  - The counter never wraps.
- **DRAIN**
  - `SLEEP_REQ`=1 and `GATE_EN`=1.
  - If `wake_cond`, return to RUN: `SLEEP_REQ`=0, counter cleared. Abort has priority over a same-cycle `SLEEP_ACK`.
  - Else if `SLEEP_ACK`, go to GATED: `GATE_EN`=0, `SLEEP_REQ`=0, `CLK_READY`=0, `GATED`=1.
- **GATED**
  - `GATE_EN`=0.
  - If `WAKE_REQ` | `FORCE_ON`, go to WAKE: `GATE_EN`=1, `GATED`=0, counter loaded with `WAKE_CYCLES`-1.
  - `BUSY` and `SLEEP_ACK` are ignored in this state.
- **WAKE**
  - `GATE_EN`=1 and `CLK_READY`=0. Counter decrements.
  - At counter 0, go to RUN: `CLK_READY`=1, counter cleared.
  - Inputs do not abort the wake sequence.
- `SLEEP_ACK` outside DRAIN is ignored.
- `SCAN_EN` has no effect on the FSM.

## Timing
- Idle entry: first idle sample at cycle k with `wake_cond` low through k+`IDLE_CYCLES`-1 gives `SLEEP_REQ`=1 at k+`IDLE_CYCLES`.
- Gate-off: `SLEEP_ACK` sampled high at cycle t in DRAIN gives `GATE_EN`=0, `GATED`=1, `CLK_READY`=0 at t+1.
- Abort: `wake_cond` sampled at t in DRAIN gives `SLEEP_REQ`=0 at t+1. `GATE_EN` never drops.
- Wake: `WAKE_REQ` sampled at t in GATED gives `GATE_EN`=1 at t+1 and `CLK_READY`=1 at t+1+`WAKE_CYCLES`.
- Minimum gated period: 1 cycle.
- `RST` mid-operation (any state): outputs return to reset values immediately, without waiting for a clock edge.
- Deassertion of `RST` must be synchronised externally to `CLK_IN`.

## Test plan
- Reset, then hold `BUSY`=0 with all requests 0 (`IDLE_CYCLES`=16): `SLEEP_REQ` rises exactly 16 cycles after reset release. `GATE_EN` stays 1.
- Idle for 15 cycles, pulse `BUSY` for 1 cycle, then stay idle: `SLEEP_REQ` rises 16 cycles after the `BUSY` pulse, not before.
- In DRAIN, assert `SLEEP_ACK` at t:
  - `GATE_EN`=0, `GATED`=1, `CLK_READY`=0 at t+1.
  - Keep `SLEEP_ACK` high and toggle `BUSY`: no state change.
- In DRAIN, assert `SLEEP_ACK` and `WAKE_REQ` in the same cycle: returns to RUN with `SLEEP_REQ`=0 and `GATE_EN` never low.
- In GATED, pulse `WAKE_REQ` at t (`WAKE_CYCLES`=2): `GATE_EN`=1 at t+1, `CLK_READY`=1 at t+3. Hold `FORCE_ON`=1 afterwards: no further `SLEEP_REQ`.
- Assert `RST` asynchronously while in GATED: `GATE_EN`=1 and `CLK_READY`=1 before the next edge. Toggle `SCAN_EN`: `GATE_TE` follows it in the same cycle in every state.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//   Enable controller for one clock domain's gated clock cell. It watches
//   domain activity. After IDLE_CYCLES consecutive idle samples it asks the
//   domain to drain, and then drops the gate enable. On a wake request it
//   raises the enable again and reports CLK_READY once the settle delay has
//   passed.
//
// Parameters
//   IDLE_CYCLES : consecutive idle samples before a sleep request (1 .. 2^CNT_W-1)
//   WAKE_CYCLES : settle cycles from enable re-assertion to CLK_READY (1 .. 2^CNT_W-1)
//   CNT_W       : width of the shared idle/wake counter
//
// Ports
//   CLK_IN    in  free-running (ungated) clock
//   RST       in  asynchronous active-high reset (deassertion synchronised externally)
//   BUSY      in  domain has work in flight
//   WAKE_REQ  in  external request to run the domain clock
//   FORCE_ON  in  software override that keeps the clock on
//   SLEEP_ACK in  domain has drained and accepts clock-off
//   SCAN_EN   in  DFT scan enable
//   GATE_EN   out EN input of the gate cell (registered)
//   GATE_TE   out TE input of the gate cell (combinational copy of SCAN_EN)
//   SLEEP_REQ out drain request to the domain (registered)
//   CLK_READY out gated clock is running and settled (registered)
//   GATED     out status: clock currently off (registered)
//   state_dbg out current FSM state, for debug and checkers
//
// Handshake: SLEEP_REQ / SLEEP_ACK is a level handshake. SLEEP_REQ is held
// high for as long as the controller is in DRAIN. It drops on the cycle after
// SLEEP_ACK is sampled high, or on the cycle after an abort caused by
// BUSY, WAKE_REQ or FORCE_ON. An abort wins over a SLEEP_ACK in the same
// cycle. SLEEP_ACK is ignored at all other times.

module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       BUSY,
  input  logic       WAKE_REQ,
  input  logic       FORCE_ON,
  input  logic       SLEEP_ACK,
  input  logic       SCAN_EN,
  output logic       GATE_EN,
  output logic       GATE_TE,
  output logic       SLEEP_REQ,
  output logic       CLK_READY,
  output logic       GATED,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wake_cond;

  assign wake_cond = BUSY | WAKE_REQ | FORCE_ON;

  // Scan must be able to open the gate cell regardless of the FSM.
  assign GATE_TE   = SCAN_EN;
  assign state_dbg = state;

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state     <= S_RUN;
      cnt       <= '0;
      GATE_EN   <= 1'b1;
      SLEEP_REQ <= 1'b0;
      CLK_READY <= 1'b1;
      GATED     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (wake_cond) begin
            cnt <= '0;
          end else if (cnt == IDLE_LAST) begin
            // This sample is idle sample number IDLE_CYCLES.
            state     <= S_DRAIN;
            SLEEP_REQ <= 1'b1;
            cnt       <= '0;
          end else if (cnt != CNT_MAX) begin
            // Saturate instead of wrapping. This also protects against a
            // misconfigured IDLE_CYCLES.
            cnt <= cnt + CNT_ONE;
          end
        end

        S_DRAIN: begin
          if (wake_cond) begin
            // Abort. The enable was never dropped, so CLK_READY stays high.
            state     <= S_RUN;
            SLEEP_REQ <= 1'b0;
            cnt       <= '0;
          end else if (SLEEP_ACK) begin
            state     <= S_GATED;
            GATE_EN   <= 1'b0;
            SLEEP_REQ <= 1'b0;
            CLK_READY <= 1'b0;
            GATED     <= 1'b1;
          end
        end

        S_GATED: begin
          // BUSY cannot change while the domain clock is stopped, so only
          // the external requests can wake it.
          if (WAKE_REQ || FORCE_ON) begin
            state   <= S_WAKE;
            GATE_EN <= 1'b1;
            GATED   <= 1'b0;
            cnt     <= WAKE_LOAD;
          end
        end

        S_WAKE: begin
          // The settle sequence always runs to completion.
          if (cnt == '0) begin
            state     <= S_RUN;
            CLK_READY <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state     <= S_RUN;
          cnt       <= '0;
          GATE_EN   <= 1'b1;
          SLEEP_REQ <= 1'b0;
          CLK_READY <= 1'b1;
          GATED     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl
//   Bench for clk_gate_ctrl with the default parameters (IDLE_CYCLES=16,
//   WAKE_CYCLES=2). It has four parts:
//     - a vector table walked from reset;
//     - hand sequences for the BUSY-pulse restart and for an asynchronous
//       reset while gated;
//     - randomised traffic checked against a cycle-level reference model.
//       The model tracks an idle streak, a pending request, a clock-off flag
//       and the remaining settle cycles.

module tb_clk_gate_ctrl;

  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, wake_req, force_on, sleep_ack, scan_en;
  logic       gate_en, gate_te, sleep_req, clk_ready, gated;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: behaviour derived from the clock-gating rules.
  bit m_req;      // sleep request outstanding
  bit m_off;      // domain clock stopped
  int m_settle;   // cycles left before the restarted clock counts as ready
  int m_idle;     // length of the current idle streak

  logic [3:0] exp_q[$];   // {gate_en, sleep_req, clk_ready, gated}

  typedef struct {
    int         n;      // cycles to hold the inputs
    logic [4:0] in;     // {busy, wake_req, force_on, sleep_ack, scan_en}
    logic [3:0] exp;    // {gate_en, sleep_req, clk_ready, gated} after n cycles
    string      name;
  } vec_t;

  vec_t vecs[15];

  clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE),
    .CNT_W(8)
  ) dut (
    .CLK_IN(clk),
    .RST(rst),
    .BUSY(busy),
    .WAKE_REQ(wake_req),
    .FORCE_ON(force_on),
    .SLEEP_ACK(sleep_ack),
    .SCAN_EN(scan_en),
    .GATE_EN(gate_en),
    .GATE_TE(gate_te),
    .SLEEP_REQ(sleep_req),
    .CLK_READY(clk_ready),
    .GATED(gated),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Model
  task automatic model_reset();
    m_req    = 1'b0;
    m_off    = 1'b0;
    m_settle = 0;
    m_idle   = 0;
  endtask

  task automatic model_step();
    bit wc;
    wc = busy | wake_req | force_on;
    if (m_off) begin
      if (wake_req | force_on) begin
        m_off    = 1'b0;
        m_settle = WAKE;
      end
    end else if (m_settle > 0) begin
      m_settle = m_settle - 1;
      m_idle   = 0;
    end else if (m_req) begin
      if (wc) begin
        m_req  = 1'b0;
        m_idle = 0;
      end else if (sleep_ack) begin
        m_req = 1'b0;
        m_off = 1'b1;
      end
    end else begin
      if (wc) m_idle = 0;
      else begin
        m_idle = m_idle + 1;
        if (m_idle == IDLE) begin
          m_req  = 1'b1;
          m_idle = 0;
        end
      end
    end
  endtask

  function automatic logic [3:0] model_out();
    return {~m_off, m_req, (~m_off && (m_settle == 0)), m_off};
  endfunction

  function automatic logic [3:0] dut_out();
    return {gate_en, sleep_req, clk_ready, gated};
  endfunction

  // Checks
  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ge/sr/cr/g=%b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drivers
  task automatic set_in(input logic [4:0] v);
    {busy, wake_req, force_on, sleep_ack, scan_en} = v;
  endtask

  // One clock: update the model at the edge, then compare just after it.
  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    exp_q.push_back(model_out());
    #1;
    check4(name, dut_out(), exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(5'b00000);
    model_reset();
    #1;
    check4("reset_async", dut_out(), 4'b1010);
    @(posedge clk);
    #1;
    check4("reset_hold", dut_out(), 4'b1010);
    rst = 1'b0;
  endtask

  // Stimulus
  initial begin
    vecs[0]  = '{15, 5'b00000, 4'b1010, "idle15"};
    vecs[1]  = '{1,  5'b00000, 4'b1110, "sleep_req_rise"};
    vecs[2]  = '{1,  5'b00011, 4'b0001, "gate_off"};
    vecs[3]  = '{3,  5'b10010, 4'b0001, "gated_busy_ack_ignored"};
    vecs[4]  = '{2,  5'b00011, 4'b0001, "gated_ack_hold"};
    vecs[5]  = '{1,  5'b01000, 4'b1000, "wake_enable"};
    vecs[6]  = '{1,  5'b00001, 4'b1000, "wake_settling"};
    vecs[7]  = '{1,  5'b00000, 4'b1010, "wake_ready"};
    vecs[8]  = '{20, 5'b00101, 4'b1010, "force_on_hold"};
    vecs[9]  = '{15, 5'b00000, 4'b1010, "idle15_again"};
    vecs[10] = '{1,  5'b00000, 4'b1110, "drain_again"};
    vecs[11] = '{1,  5'b01010, 4'b1010, "abort_beats_ack"};
    vecs[12] = '{15, 5'b00011, 4'b1010, "idle_after_abort"};
    vecs[13] = '{1,  5'b00000, 4'b1110, "drain_third"};
    vecs[14] = '{2,  5'b10001, 4'b1010, "busy_abort"};

    do_reset();

    // Vector table
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].in);
      #1;
      check1({vecs[i].name, "_te"}, gate_te, vecs[i].in[0]);
      for (int c = 0; c < vecs[i].n; c++) tick(vecs[i].name);
      check4(vecs[i].name, dut_out(), vecs[i].exp);
    end

    // A BUSY pulse after 15 idle cycles restarts the idle count.
    do_reset();
    set_in(5'b00000);
    for (int c = 0; c < 15; c++) tick("pulse_pre_idle");
    set_in(5'b10000);
    tick("pulse_busy");
    set_in(5'b00000);
    for (int c = 0; c < 15; c++) tick("pulse_post_idle");
    check1("pulse_no_early_req", sleep_req, 1'b0);
    tick("pulse_post_idle");
    check1("pulse_req_after16", sleep_req, 1'b1);

    // Asynchronous reset while gated.
    set_in(5'b00010);
    tick("to_gated");
    check4("in_gated", dut_out(), 4'b0001);
    @(posedge clk);
    model_step();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check4("async_rst_gated", dut_out(), 4'b1010);
    scan_en = 1'b1;
    #1;
    check1("te_in_reset_hi", gate_te, 1'b1);
    scan_en = 1'b0;
    #1;
    check1("te_in_reset_lo", gate_te, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check4("rnd_rst", dut_out(), 4'b1010);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      busy      = ($urandom_range(0, 39) == 0);
      wake_req  = ($urandom_range(0, 59) == 0);
      force_on  = ($urandom_range(0, 99) == 0);
      sleep_ack = ($urandom_range(0, 2) == 0);
      scan_en   = 1'($urandom_range(0, 1));
      #1;
      check1("rnd_te", gate_te, scan_en);
      tick("rnd");
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
